// File: rtl/mul_qf_b_pkg.sv
// Shared types and default widths for the Q.F shift-add multiplier.
// Default widths match the companion Q.F divider.
package mul_qf_b_pkg;

    localparam int unsigned DefMA = 8;
    localparam int unsigned DefMB = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StRound
    } state_e;

endpackage

// File: rtl/qf_shift_add_dp.sv
// Shift-add datapath for mul_qf_b: holds acc/mcand/cnt and the add-then-shift-right adder.
// prod is the next accumulator value, or the settled accumulator when sel is high.
module qf_shift_add_dp
    import mul_qf_b_pkg::*;
#(
    parameter int unsigned M_A = DefMA,
    parameter int unsigned M_B = DefMB
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   step,
    input  logic                   sel,
    input  logic [M_A-1:0]         Q,
    input  logic [M_B-1:0]         F,
    input  logic [M_B-1:0]         B,
    output logic                   last,
    output logic [M_A+2*M_B-1:0]   prod
);

    localparam int unsigned N    = M_A + M_B;
    localparam int unsigned W    = N + M_B;
    localparam int unsigned CntW = $clog2(N);

    logic [W-1:0]    acc_q, acc_next;
    logic [N-1:0]    mcand_q;
    logic [M_B-1:0]  mult_q;
    logic [CntW-1:0] cnt_q;
    logic [M_B:0]    sum;

    // Add the multiplier into the top M_B bits, keep the carry, then shift right by one.
    always_comb begin
        sum      = {1'b0, acc_q[W-1:N]} + {1'b0, mult_q & {M_B{mcand_q[0]}}};
        acc_next = {sum, acc_q[N-1:1]};
        prod     = sel ? acc_q : acc_next;
        last     = (cnt_q == CntW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mult_q  <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            acc_q   <= '0;
            mcand_q <= {Q, F};
            mult_q  <= B;
            cnt_q   <= '0;
        end else if (step) begin
            acc_q   <= acc_next;
            mcand_q <= mcand_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mul_qf_b.sv
// Sequential Q.F * B multiplier, one multiplicand bit per clock, st/ok_mul pulse handshake.
// Optional MUL_QF_ROUND_EN adds a one-cycle ROUND state (round half up on A_rec).
module mul_qf_b
    import mul_qf_b_pkg::*;
#(
    parameter int unsigned M_A = DefMA,
    parameter int unsigned M_B = DefMB
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 st,
    input  logic [M_A-1:0]       Q,
    input  logic [M_B-1:0]       F,
    input  logic [M_B-1:0]       B,
    output logic [M_A+M_B-1:0]   A_rec,
    output logic [M_B-1:0]       R,
    output logic                 ovf,
    output logic                 busy,
    output logic                 ok_mul
);

    localparam int unsigned N = M_A + M_B;

    state_e            state_q, state_d;
    logic              load, step, sel, last, fin;
    logic [N+M_B-1:0]  prod;
    logic [N-1:0]      trunc, a_rec_d, a_rec_q;
    logic [M_B-1:0]    frac, r_q;
    logic              ovf_q, ok_q;

    qf_shift_add_dp #(
        .M_A (M_A),
        .M_B (M_B)
    ) u_dp (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .sel  (sel),
        .Q    (Q),
        .F    (F),
        .B    (B),
        .last (last),
        .prod (prod)
    );

    // A new st always wins over the current state; a completion on the same edge still reports.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        case (state_q)
            StIdle: begin
                if (st) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                step = 1'b1;
                if (last) begin
`ifdef MUL_QF_ROUND_EN
                    state_d = StRound;
`else
                    fin     = 1'b1;
                    state_d = StIdle;
`endif
                end
                if (st) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRound: begin
                fin     = 1'b1;
                state_d = StIdle;
                if (st) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sel   = (state_q == StRound);
        trunc = prod[N+M_B-1:M_B];
        frac  = prod[M_B-1:0];
`ifdef MUL_QF_ROUND_EN
        a_rec_d = trunc + {{(N-1){1'b0}}, frac[M_B-1]};
`else
        a_rec_d = trunc;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_rec_q <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ok_q    <= fin;
            if (fin) begin
                a_rec_q <= a_rec_d;
                r_q     <= frac;
                ovf_q   <= |a_rec_d[N-1:M_A];
            end
        end
    end

    assign A_rec  = a_rec_q;
    assign R      = r_q;
    assign ovf    = ovf_q;
    assign ok_mul = ok_q;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_mul_qf_b.sv
// Randomised self-checking bench for mul_qf_b (M_A=M_B=8) against an arithmetic reference model.
module tb_mul_qf_b;

`ifdef MUL_QF_ROUND_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif
    localparam int MAXW = 40;

    logic        clk, rst, st;
    logic [7:0]  Q, F, B;
    logic [15:0] A_rec;
    logic [7:0]  R;
    logic        ovf, busy, ok_mul;

    int n_checks = 0;
    int n_fail   = 0;

    mul_qf_b #(
        .M_A (8),
        .M_B (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .st     (st),
        .Q      (Q),
        .F      (F),
        .B      (B),
        .A_rec  (A_rec),
        .R      (R),
        .ovf    (ovf),
        .busy   (busy),
        .ok_mul (ok_mul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: real-valued Q.F times B, split into integer and fraction parts.
    function automatic void model(input logic [7:0] q, input logic [7:0] f, input logic [7:0] b,
                                  output logic [15:0] a, output logic [7:0] r, output logic o);
        int unsigned p, ai;
        p = (int'(q) * 256 + int'(f)) * int'(b);
        r = 8'(p % 256);
`ifdef MUL_QF_ROUND_EN
        ai = (p + 128) / 256;
`else
        ai = p / 256;
`endif
        a = 16'(ai);
        o = (ai > 255);
    endfunction

    // Pulse st with operands, then count edges until ok_mul (bounded).
    task automatic run_op(input logic [7:0] q, input logic [7:0] f, input logic [7:0] b,
                          output int lat, output logic busy0);
        @(negedge clk);
        st = 1'b1; Q = q; F = f; B = b;
        @(posedge clk); #1;
        st = 1'b0;
        busy0 = busy;
        lat = 0;
        while (ok_mul !== 1'b1 && lat < MAXW) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; st = 1'b0; Q = '0; F = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (A_rec !== 16'h0) begin n_fail++; $display("FAIL reset A_rec got %h want 0", A_rec); end
        n_checks++; if (R !== 8'h0) begin n_fail++; $display("FAIL reset R got %h want 0", R); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset ovf got %b want 0", ovf); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
        n_checks++; if (ok_mul !== 1'b0) begin n_fail++; $display("FAIL reset ok_mul got %b want 0", ok_mul); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [7:0] tq [4] = '{8'd3, 8'd14, 8'hFF, 8'd5};
        logic [7:0] tf [4] = '{8'h80, 8'h49, 8'hFF, 8'h00};
        logic [7:0] tb [4] = '{8'd10, 8'd7, 8'hFF, 8'd0};
`ifdef MUL_QF_ROUND_EN
        logic [15:0] ta [4] = '{16'd35, 16'd100, 16'hFEFF, 16'd0};
`else
        logic [15:0] ta [4] = '{16'd35, 16'd99, 16'hFEFF, 16'd0};
`endif
        logic [7:0] tr [4] = '{8'h00, 8'hFF, 8'h01, 8'h00};
        logic       to [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int lat; logic b0;
        for (int i = 0; i < 4; i++) begin
            run_op(tq[i], tf[i], tb[i], lat, b0);
            n_checks++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL dir%0d busy got %b want 1", i, b0); end
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL dir%0d latency got %0d want %0d", i, lat, LAT); end
            n_checks++; if (A_rec !== ta[i]) begin n_fail++; $display("FAIL dir%0d A_rec got %h want %h", i, A_rec, ta[i]); end
            n_checks++; if (R !== tr[i]) begin n_fail++; $display("FAIL dir%0d R got %h want %h", i, R, tr[i]); end
            n_checks++; if (ovf !== to[i]) begin n_fail++; $display("FAIL dir%0d ovf got %b want %b", i, ovf, to[i]); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dir%0d busy at done got %b want 0", i, busy); end
            @(posedge clk); #1;
            n_checks++; if (ok_mul !== 1'b0) begin n_fail++; $display("FAIL dir%0d ok_mul held got %b want 0", i, ok_mul); end
            n_checks++; if (A_rec !== ta[i]) begin n_fail++; $display("FAIL dir%0d A_rec hold got %h want %h", i, A_rec, ta[i]); end
        end
    endtask

    task automatic test_random;
        logic [7:0] q, f, b, er; logic [15:0] ea; logic eo; int lat; logic b0;
        for (int i = 0; i < 40; i++) begin
            q = 8'($urandom); f = 8'($urandom); b = 8'($urandom);
            if (i % 8 == 0) q = 8'($urandom_range(0, 1));
            model(q, f, b, ea, er, eo);
            run_op(q, f, b, lat, b0);
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rand%0d latency got %0d want %0d", i, lat, LAT); end
            n_checks++; if (A_rec !== ea) begin n_fail++; $display("FAIL rand%0d A_rec got %h want %h", i, A_rec, ea); end
            n_checks++; if (R !== er) begin n_fail++; $display("FAIL rand%0d R got %h want %h", i, R, er); end
            n_checks++; if (ovf !== eo) begin n_fail++; $display("FAIL rand%0d ovf got %b want %b", i, ovf, eo); end
        end
    endtask

    task automatic test_rst_mid;
        int oks, lat; logic b0; logic [7:0] er; logic [15:0] ea; logic eo;
        @(negedge clk);
        st = 1'b1; Q = 8'd3; F = 8'h80; B = 8'd10;
        @(posedge clk); #1;
        st = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (A_rec !== 16'h0) begin n_fail++; $display("FAIL rstmid A_rec got %h want 0", A_rec); end
        n_checks++; if (R !== 8'h0) begin n_fail++; $display("FAIL rstmid R got %h want 0", R); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid busy got %b want 0", busy); end
        @(negedge clk); rst = 1'b0;
        oks = 0;
        repeat (24) begin @(posedge clk); #1; if (ok_mul === 1'b1) oks++; end
        n_checks++; if (oks != 0) begin n_fail++; $display("FAIL rstmid stray ok_mul count got %0d want 0", oks); end
        model(8'd3, 8'h80, 8'd10, ea, er, eo);
        run_op(8'd3, 8'h80, 8'd10, lat, b0);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rstmid next latency got %0d want %0d", lat, LAT); end
        n_checks++; if (A_rec !== ea) begin n_fail++; $display("FAIL rstmid next A_rec got %h want %h", A_rec, ea); end
    endtask

    task automatic test_restart;
        int oks, first, lat;
        logic [15:0] a_at;
        @(negedge clk);
        st = 1'b1; Q = 8'd14; F = 8'h49; B = 8'd7;
        @(posedge clk); #1;
        st = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        st = 1'b1; Q = 8'd2; F = 8'd0; B = 8'd9;
        @(posedge clk); #1;
        st = 1'b0;
        oks = 0; first = -1; a_at = 16'hxxxx;
        for (lat = 1; lat <= MAXW; lat++) begin
            @(posedge clk); #1;
            if (ok_mul === 1'b1) begin
                oks++;
                if (first < 0) begin first = lat; a_at = A_rec; end
            end
        end
        n_checks++; if (oks != 1) begin n_fail++; $display("FAIL restart ok_mul count got %0d want 1", oks); end
        n_checks++; if (first != LAT) begin n_fail++; $display("FAIL restart latency got %0d want %0d", first, LAT); end
        n_checks++; if (a_at !== 16'd18) begin n_fail++; $display("FAIL restart A_rec got %h want %h", a_at, 16'd18); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] er1, er2; logic [15:0] ea1, ea2; logic eo1, eo2; int lat;
        model(8'd3, 8'h80, 8'd10, ea1, er1, eo1);
        model(8'hFF, 8'hFF, 8'hFF, ea2, er2, eo2);
        @(negedge clk);
        st = 1'b1; Q = 8'd3; F = 8'h80; B = 8'd10;
        @(posedge clk); #1;
        st = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        st = 1'b1; Q = 8'hFF; F = 8'hFF; B = 8'hFF;
        @(posedge clk); #1;
        st = 1'b0;
        n_checks++; if (ok_mul !== 1'b1) begin n_fail++; $display("FAIL b2b first ok_mul got %b want 1", ok_mul); end
        n_checks++; if (A_rec !== ea1) begin n_fail++; $display("FAIL b2b first A_rec got %h want %h", A_rec, ea1); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b restart busy got %b want 1", busy); end
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (ok_mul !== 1'b1 && lat < MAXW);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL b2b second latency got %0d want %0d", lat, LAT); end
        n_checks++; if (A_rec !== ea2) begin n_fail++; $display("FAIL b2b second A_rec got %h want %h", A_rec, ea2); end
        n_checks++; if (ovf !== eo2) begin n_fail++; $display("FAIL b2b second ovf got %b want %b", ovf, eo2); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_rst_mid();
        test_restart();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
